// File: rtl/voice_scheduler.sv
// Voice allocator: maps MIDI note-on/off events onto NUM_VOICES divider channels,
// reusing a matching voice, else a free one, else stealing the oldest sounding voice.
module voice_scheduler #(
  parameter int NUM_VOICES = 8,
  parameter int DIV_W      = 27,
  parameter int AGE_W      = 8
) (
  input  logic                        clock,
  input  logic                        clr_n,
  input  logic                        evt_valid,
  output logic                        evt_ready,
  input  logic                        evt_on,
  input  logic [6:0]                  evt_note,
  input  logic [DIV_W-1:0]            evt_div,
  input  logic                        panic,
  output logic [NUM_VOICES-1:0]       voice_gate,
  output logic [NUM_VOICES*DIV_W-1:0] voice_div,
  output logic [NUM_VOICES*7-1:0]     voice_note,
  output logic [NUM_VOICES-1:0]       voice_clr,
  output logic                        stolen
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t state, state_next;

  logic                  accept;
  logic                  ev_on;
  logic [6:0]            ev_note;
  logic [DIV_W-1:0]      ev_div;
  logic [IDX_W-1:0]      idx;

  logic                  match_found, free_found, old_found;
  logic [IDX_W-1:0]      match_idx, free_idx, old_idx;
  logic [AGE_W-1:0]      old_age;

  logic [NUM_VOICES-1:0] gate_q;
  logic [DIV_W-1:0]      div_q  [NUM_VOICES];
  logic [6:0]            note_q [NUM_VOICES];
  logic [AGE_W-1:0]      age_q  [NUM_VOICES];

  logic                  commit_on, commit_off, commit_steal;
  logic [IDX_W-1:0]      target;

  assign evt_ready = (state == IDLE) && !panic;
  assign accept    = evt_valid && evt_ready;

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SCAN;
      SCAN:    if (idx == LAST_IDX) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (panic) state_next = IDLE;
  end

  // One voice is examined per SCAN cycle; voice state is frozen meanwhile.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      ev_on       <= 1'b0;
      ev_note     <= '0;
      ev_div      <= '0;
      idx         <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      old_found   <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      old_idx     <= '0;
      old_age     <= '0;
    end else if (accept) begin
      ev_on       <= evt_on;
      ev_note     <= evt_note;
      ev_div      <= evt_div;
      idx         <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      old_found   <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      old_idx     <= '0;
      old_age     <= '0;
    end else if (state == SCAN) begin
      if (gate_q[idx] && (note_q[idx] == ev_note) && !match_found) begin
        match_found <= 1'b1;
        match_idx   <= idx;
      end
      if (!gate_q[idx] && !free_found) begin
        free_found <= 1'b1;
        free_idx   <= idx;
      end
      if (gate_q[idx] && (!old_found || (age_q[idx] > old_age))) begin
        old_found <= 1'b1;
        old_idx   <= idx;
        old_age   <= age_q[idx];
      end
      idx <= idx + 1'b1;
    end
  end

  always_comb begin
    commit_on    = 1'b0;
    commit_off   = 1'b0;
    commit_steal = 1'b0;
    target       = '0;
    if ((state == COMMIT) && !panic) begin
      if (ev_on) begin
        if (ev_div != '0) begin
          if (match_found) begin
            commit_on = 1'b1;
            target    = match_idx;
          end else if (free_found) begin
            commit_on = 1'b1;
            target    = free_idx;
          end else if (old_found) begin
            commit_on    = 1'b1;
            commit_steal = 1'b1;
            target       = old_idx;
          end
        end
      end else if (match_found) begin
        commit_off = 1'b1;
        target     = match_idx;
      end
    end
  end

  // Voice bank: changes only at a commit, a panic or a reset.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      gate_q    <= '0;
      voice_clr <= '0;
      stolen    <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        div_q[v]  <= '0;
        note_q[v] <= '0;
        age_q[v]  <= '0;
      end
    end else begin
      voice_clr <= '0;
      stolen    <= 1'b0;
      if (panic) begin
        gate_q <= '0;
        for (int v = 0; v < NUM_VOICES; v++) age_q[v] <= '0;
      end else if (commit_on) begin
        stolen <= commit_steal;
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (target == IDX_W'(v)) begin
            gate_q[v]    <= 1'b1;
            note_q[v]    <= ev_note;
            div_q[v]     <= ev_div;
            age_q[v]     <= '0;
            voice_clr[v] <= 1'b1;
          end else if (gate_q[v] && (age_q[v] != AGE_MAX)) begin
            age_q[v] <= age_q[v] + 1'b1;
          end
        end
      end else if (commit_off) begin
        gate_q[target] <= 1'b0;
      end
    end
  end

  assign voice_gate = gate_q;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_flat
    assign voice_div[v*DIV_W +: DIV_W] = div_q[v];
    assign voice_note[v*7 +: 7]        = note_q[v];
  end

endmodule
